// File: rtl/connect4_draw_pkg.sv
// rtl/connect4_draw_pkg.sv - shared states, board geometry and clamp helper for the sprite sequencer
package connect4_draw_pkg;

  typedef enum logic [2:0] {IDLE, ERASE, DRAW, FLUSH, DONE} state_e;

  localparam int X0         = 37;
  localparam int Y0         = 89;
  localparam int PITCH      = 13;
  localparam int CURSOR_Y   = 11;
  localparam int MAX_COL    = 6;
  localparam int MAX_ROW    = 5;
  localparam int SPRITE_DIM = 8;

  function automatic logic [2:0] clamp3(input logic [2:0] v, input int lim);
    return (int'(v) > lim) ? 3'(lim) : v;
  endfunction

endpackage

// File: rtl/connect4_draw_ctrl_if.sv
// rtl/connect4_draw_ctrl_if.sv - request, sprite-memory and VGA adapter signals of the draw controller
interface connect4_draw_ctrl_if;
  logic       req_place;
  logic [2:0] place_col;
  logic [2:0] place_row;
  logic       place_p2;
  logic       req_cursor;
  logic [2:0] cursor_col;
  logic       cursor_p2;
  logic [2:0] q_p1;
  logic [2:0] q_p2;
  logic [5:0] mem_addr;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       ack_place;
  logic       ack_cursor;
  logic       busy;
  logic       done;

  modport master (
    output req_place, place_col, place_row, place_p2,
    output req_cursor, cursor_col, cursor_p2, q_p1, q_p2,
    input  mem_addr, vga_x, vga_y, vga_colour, vga_plot,
    input  ack_place, ack_cursor, busy, done
  );

  modport slave (
    input  req_place, place_col, place_row, place_p2,
    input  req_cursor, cursor_col, cursor_p2, q_p1, q_p2,
    output mem_addr, vga_x, vga_y, vga_colour, vga_plot,
    output ack_place, ack_cursor, busy, done
  );
endinterface

// File: rtl/connect4_draw_ctrl_blit_align.sv
// rtl/connect4_draw_ctrl_blit_align.sv - delays pixel position by the sprite memory latency and picks the colour
module blit_align (
  input  logic       clk,
  input  logic       rst,
  input  logic       plot_in,
  input  logic       erase_in,
  input  logic       sel_in,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [2:0] q_p1,
  input  logic [2:0] q_p2,
  output logic       vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour
);
  logic       plot_q, plot_d;
  logic       erase_q, erase_d;
  logic       sel_q, sel_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;

  always_comb begin
    plot_d  = plot_in;
    erase_d = erase_in;
    sel_d   = sel_in;
    x_d     = x_in;
    y_d     = y_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      plot_q  <= 1'b0;
      erase_q <= 1'b0;
      sel_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      plot_q  <= plot_d;
      erase_q <= erase_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // memory data arrives now for the address registered alongside x_q/y_q
  assign vga_colour = (plot_q && !erase_q) ? (sel_q ? q_p2 : q_p1) : 3'b000;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
endmodule

// File: rtl/connect4_draw_ctrl.sv
// rtl/connect4_draw_ctrl.sv - arbitrates place/cursor requests and sequences 8x8 sprite blits to the VGA adapter
module connect4_draw_ctrl #(
  parameter int X0       = connect4_draw_pkg::X0,
  parameter int Y0       = connect4_draw_pkg::Y0,
  parameter int PITCH    = connect4_draw_pkg::PITCH,
  parameter int CURSOR_Y = connect4_draw_pkg::CURSOR_Y
) (
  input  logic                clk,
  input  logic                rst,
  connect4_draw_ctrl_if.slave bus
);
  import connect4_draw_pkg::*;

  state_e     state_q, state_d;
  logic [5:0] k_q, k_d;
  logic [7:0] base_x_q, base_x_d;
  logic [6:0] base_y_q, base_y_d;
  logic [7:0] old_x_q, old_x_d;
  logic       sel_q, sel_d;
  logic       job_cursor_q, job_cursor_d;
  logic       cursor_valid_q, cursor_valid_d;
  logic       ack_place_q, ack_place_d;
  logic       ack_cursor_q, ack_cursor_d;

  logic [2:0] place_col_c, place_row_c, cursor_col_c;
  logic       last_k;
  logic       plot_in, erase_in;
  logic [7:0] x_in;
  logic [6:0] y_in;

  assign place_col_c  = clamp3(bus.place_col, MAX_COL);
  assign place_row_c  = clamp3(bus.place_row, MAX_ROW);
  assign cursor_col_c = clamp3(bus.cursor_col, MAX_COL);
  assign last_k       = (k_q == 6'(SPRITE_DIM * SPRITE_DIM - 1));

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    base_x_d       = base_x_q;
    base_y_d       = base_y_q;
    old_x_d        = old_x_q;
    sel_d          = sel_q;
    job_cursor_d   = job_cursor_q;
    cursor_valid_d = cursor_valid_q;
    ack_place_d    = 1'b0;
    ack_cursor_d   = 1'b0;
    case (state_q)
      IDLE: begin
        k_d = '0;
        if (bus.req_place) begin
          base_x_d     = 8'(X0 + PITCH * int'(place_col_c));
          base_y_d     = 7'(Y0 - PITCH * int'(place_row_c));
          sel_d        = bus.place_p2;
          job_cursor_d = 1'b0;
          ack_place_d  = 1'b1;
          state_d      = DRAW;
        end else if (bus.req_cursor) begin
          base_x_d     = 8'(X0 + PITCH * int'(cursor_col_c));
          base_y_d     = 7'(CURSOR_Y);
          sel_d        = bus.cursor_p2;
          job_cursor_d = 1'b1;
          ack_cursor_d = 1'b1;
          state_d      = cursor_valid_q ? ERASE : DRAW;
        end
      end
      // k wraps to 0 on the last pixel, so DRAW starts without a bubble
      ERASE: begin
        k_d = k_q + 6'd1;
        if (last_k) state_d = DRAW;
      end
      DRAW: begin
        k_d = k_q + 6'd1;
        if (last_k) state_d = FLUSH;
      end
      FLUSH: state_d = DONE;
      DONE: begin
        if (job_cursor_q) begin
          old_x_d        = base_x_q;
          cursor_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      base_x_q       <= '0;
      base_y_q       <= '0;
      old_x_q        <= '0;
      sel_q          <= 1'b0;
      job_cursor_q   <= 1'b0;
      cursor_valid_q <= 1'b0;
      ack_place_q    <= 1'b0;
      ack_cursor_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      base_x_q       <= base_x_d;
      base_y_q       <= base_y_d;
      old_x_q        <= old_x_d;
      sel_q          <= sel_d;
      job_cursor_q   <= job_cursor_d;
      cursor_valid_q <= cursor_valid_d;
      ack_place_q    <= ack_place_d;
      ack_cursor_q   <= ack_cursor_d;
    end
  end

  assign plot_in  = (state_q == ERASE) || (state_q == DRAW);
  assign erase_in = (state_q == ERASE);
  assign x_in     = (erase_in ? old_x_q : base_x_q) + {5'd0, k_q[2:0]};
  assign y_in     = (erase_in ? 7'(CURSOR_Y) : base_y_q) + {4'd0, k_q[5:3]};

  assign bus.mem_addr   = k_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.ack_place  = ack_place_q;
  assign bus.ack_cursor = ack_cursor_q;

  blit_align u_align (
    .clk        (clk),
    .rst        (rst),
    .plot_in    (plot_in),
    .erase_in   (erase_in),
    .sel_in     (sel_q),
    .x_in       (x_in),
    .y_in       (y_in),
    .q_p1       (bus.q_p1),
    .q_p2       (bus.q_p2),
    .vga_plot   (bus.vga_plot),
    .vga_x      (bus.vga_x),
    .vga_y      (bus.vga_y),
    .vga_colour (bus.vga_colour)
  );
endmodule

// File: tb/tb_connect4_draw_ctrl.sv
// tb/tb_connect4_draw_ctrl.sv - scoreboard bench for the connect-4 sprite draw controller
module tb_connect4_draw_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  connect4_draw_ctrl_if bus ();

  connect4_draw_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } plot_t;

  plot_t      sb[$];
  logic [2:0] mem1[64];
  logic [2:0] mem2[64];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         cv_m = 0;
  int         old_xm = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.q_p1 <= mem1[bus.mem_addr];
    bus.q_p2 <= mem2[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // pixel k of a sprite sits at column k%8, row k/8 from its origin
  task automatic push_sprite(input int bx, input int by, input bit erase, input bit p2, input int n);
    for (int k = 0; k < n; k++) begin
      plot_t p;
      p.x = 8'(bx + k % 8);
      p.y = 7'(by + k / 8);
      p.c = erase ? 3'd0 : (p2 ? mem2[k] : mem1[k]);
      sb.push_back(p);
    end
  endtask

  task automatic model_place(input int col, input int row, input bit p2, input int n);
    push_sprite(37 + 13 * clampi(col, 6), 89 - 13 * clampi(row, 5), 1'b0, p2, n);
  endtask

  task automatic model_cursor(input int col, input bit p2);
    int nx;
    nx = 37 + 13 * clampi(col, 6);
    if (cv_m) push_sprite(old_xm, 11, 1'b1, 1'b0, 64);
    push_sprite(nx, 11, 1'b0, p2, 64);
    cv_m   = 1'b1;
    old_xm = nx;
  endtask

  always @(negedge clk) begin : monitor
    plot_t e;
    if (bus.vga_plot === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d required no plot", bus.vga_x, bus.vga_y);
      end else begin
        e = sb.pop_front();
        chk("plot_xyc", {14'd0, bus.vga_x, bus.vga_y, bus.vga_colour}, {14'd0, e});
      end
    end
  end

  task automatic serve(input bit dp, input bit dc, input int pc, input int pr, input bit pp2,
                       input int cc, input bit cp2);
    int dq[$];
    bit aq[$];
    int ack_cyc;
    int ndone;
    int nexp;
    int lat;
    bit prev_done;
    bit e;
    ack_cyc   = 0;
    ndone     = 0;
    prev_done = 1'b0;
    nexp      = int'(dp) + int'(dc);
    if (dp) begin
      model_place(pc, pr, pp2, 64);
      dq.push_back(65);
      aq.push_back(1'b0);
    end
    if (dc) begin
      dq.push_back(cv_m ? 129 : 65);
      aq.push_back(1'b1);
      model_cursor(cc, cp2);
    end
    bus.place_col  = 3'(pc);
    bus.place_row  = 3'(pr);
    bus.place_p2   = pp2;
    bus.cursor_col = 3'(cc);
    bus.cursor_p2  = cp2;
    bus.req_place  = dp;
    bus.req_cursor = dc;
    for (int i = 0; i < 600 && ndone < nexp; i++) begin
      @(negedge clk);
      if (prev_done) chk("busy_after_done", 32'(bus.busy), 32'd0);
      prev_done = 1'b0;
      if (bus.ack_place || bus.ack_cursor) begin
        e = 1'b0;
        if (aq.size() != 0) e = aq.pop_front();
        chk("ack_order", {30'd0, bus.ack_place, bus.ack_cursor}, e ? 32'd1 : 32'd2);
        chk("busy_at_ack", 32'(bus.busy), 32'd1);
        ack_cyc = cyc;
        if (bus.ack_place) bus.req_place = 1'b0;
        if (bus.ack_cursor) bus.req_cursor = 1'b0;
      end
      if (bus.done) begin
        lat = -1;
        if (dq.size() != 0) lat = dq.pop_front();
        chk("done_latency", 32'(cyc - ack_cyc), 32'(lat));
        ndone++;
        prev_done = 1'b1;
      end
    end
    chk("serve_done_count", 32'(ndone), 32'(nexp));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    bus.req_place  = 1'b0;
    bus.req_cursor = 1'b0;
    @(negedge clk);
    chk("idle_after_job", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    bit got;
    for (int k = 0; k < 64; k++) begin
      mem1[k] = 3'($urandom_range(0, 7));
      mem2[k] = 3'($urandom_range(0, 7));
    end
    rst            = 1'b1;
    bus.req_place  = 1'b0;
    bus.req_cursor = 1'b0;
    bus.place_col  = '0;
    bus.place_row  = '0;
    bus.place_p2   = 1'b0;
    bus.cursor_col = '0;
    bus.cursor_p2  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_plot", 32'(bus.vga_plot), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_acks", {30'd0, bus.ack_place, bus.ack_cursor}, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_xyc", {14'd0, bus.vga_x, bus.vga_y, bus.vga_colour}, 32'd0);
    rst = 1'b0;
    np = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.vga_plot) np++;
    end
    chk("idle_no_plot", 32'(np), 32'd0);

    serve(1'b1, 1'b0, 3, 2, 1'b1, 0, 1'b0);
    serve(1'b0, 1'b1, 0, 0, 1'b0, 0, 1'b0);
    serve(1'b0, 1'b1, 0, 0, 1'b0, 4, 1'b1);
    serve(1'b1, 1'b1, 1, 0, 1'b0, 2, 1'b0);
    serve(1'b1, 1'b0, 7, 7, 1'b0, 0, 1'b0);

    for (int it = 0; it < 10; it++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      serve(kind != 1, kind != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // reset lands on the edge after pixel k = 30 is addressed; 30 pixels reach the screen
    model_place(2, 1, 1'b0, 30);
    bus.place_col = 3'd2;
    bus.place_row = 3'd1;
    bus.place_p2  = 1'b0;
    bus.req_place = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ack_place) begin
        got = 1'b1;
        break;
      end
    end
    chk("mid_reset_ack", 32'(got), 32'd1);
    bus.req_place = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_plot", 32'(bus.vga_plot), 32'd0);
    chk("mid_reset_busy", 32'(bus.busy), 32'd0);
    chk("mid_reset_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_reset_sb", 32'(sb.size()), 32'd0);
    rst    = 1'b0;
    cv_m   = 1'b0;
    old_xm = 0;
    serve(1'b0, 1'b1, 0, 0, 1'b0, 5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/connect4_draw_ctrl.md
# connect4_draw_ctrl

Sequencer and arbiter for the 160x120 VGA sprite path of the Connect-4 display. It accepts piece-placement and hover-cursor requests and converts board coordinates (column, row) to pixel origins. It walks the 8x8 sprite memories through all 64 addresses and drives the adapter's x/y/colour/plot with the memory's one-cycle latency absorbed. Cursor moves erase the previous cursor sprite before drawing the new one.

## Interface
Parameters:
- X0, 37, pixel x of column 0
- Y0, 89, pixel y of row 0 (bottom row)
- PITCH, 13, cell pitch in pixels (x and y)
- CURSOR_Y, 11, pixel y of cursor sprite row

Ports (one clock; reset is synchronous and active-high):
- Clock  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high
- req_place  in  1  placement request; held until ack_place
- place_col  in  3  column 0..6
- place_row  in  3  row 0..5 (count of pieces already in column)
- place_p2  in  1  1 = player-2 sprite, 0 = player-1 sprite
- req_cursor  in  1  cursor request; held until ack_cursor
- cursor_col  in  3  new cursor column 0..6
- cursor_p2  in  1  sprite select for cursor
- q_p1  in  3  player-1 sprite memory data (1-cycle read latency)
- q_p2  in  3  player-2 sprite memory data (1-cycle read latency)
- mem_addr  out  6  sprite address {row[2:0], col[2:0]}
- vga_x  out  8  pixel x
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write-enable to the VGA adapter
- ack_place, ack_cursor  out  1  one-cycle grant pulses
- busy  out  1  high from grant until done
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, ERASE, DRAW, FLUSH, DONE.
- IDLE:
  - req_place wins over req_cursor when both are high.
  - On grant, latch base_x, base_y and sprite select; clear k (6-bit pixel counter).
  - Place grant → DRAW.
  - Cursor grant → ERASE if cursor_valid is set, else DRAW.
- Coordinates:
  - Column is clamped to 6; row is clamped to 5.
  - base_x = X0 + PITCH*col, range 37..115.
  - Place: base_y = Y0 − PITCH*row, range 89..24.
  - Cursor: base_y = CURSOR_Y.
- ERASE: walks k = 0..63 at the old cursor base (old_x, CURSOR_Y). Colour is forced to 3'b000 and the memories are ignored. After k = 63 → DRAW with k = 0, no bubble.
- DRAW:
  - mem_addr = k.
  - One cycle later: vga_plot = 1, vga_x = base_x + k[2:0], vga_y = base_y + k[5:3], vga_colour = selected q.
  - After k = 63 → FLUSH.
- FLUSH: last pipelined pixel is plotted; → DONE.
- DONE: done = 1. If the job was a cursor job: old_x ← base_x and cursor_valid ← 1. → IDLE.
- Requests arriving while busy are not acknowledged. Requesters hold their requests, and the pending request is served on return to IDLE.
- Width rules:
  - Max x = 115 + 7 = 122 (fits 8 bits).
  - y range is 11..96 (fits 7 bits).
  - All arithmetic is unsigned; no wrap is possible within the clamped ranges.
- Reset (any state, including mid-sprite) has the following effects:
  - state ← IDLE and k ← 0.
  - cursor_valid ← 0 and old_x ← 0.
  - All outputs ← 0: vga_plot, busy, ack_*, done, mem_addr, vga_x, vga_y, vga_colour.
  - A partially drawn sprite is left on screen.

## Timing
- Grant sampled in IDLE at edge T: ack_* = 1 and busy = 1 during cycle T+1, when the first address is also presented.
- Place or first cursor (no erase):
  - Addresses k = 0..63 at T+1..T+64.
  - Plots at T+2..T+65 (64 cycles, contiguous).
  - done at T+66; back in IDLE (busy = 0) at T+67.
- Cursor with erase:
  - Erase plots at T+2..T+65; draw plots at T+66..T+129.
  - done at T+130.
- vga_plot is never asserted for more than 64 consecutive cycles per sprite phase, and never in IDLE or DONE.
- Back-to-back: a request held through DONE is granted on the first IDLE cycle, giving a minimum gap of 2 cycles between sprites.

## Structure
- Shared package connect4_draw_pkg contains:
  - state enum {IDLE, ERASE, DRAW, FLUSH, DONE}
  - constants X0, Y0, PITCH, CURSOR_Y
  - MAX_COL = 6, MAX_ROW = 5, SPRITE_DIM = 8
- One sub-module, blit_align: a registered stage that delays {plot, x, y, erase_flag} by one cycle to match sprite memory latency, and muxes the colour (erase → 0, else q_p1/q_p2).
- The top level contains the FSM, arbiter, clamp/coordinate math, counter and cursor_valid/old_x registers.

## Test plan
- Reset then idle: all outputs 0; no plot for 100 cycles.
- Place col 3, row 2, p2 = 1, request at T:
  - ack_place at T+1.
  - First plot (76,63) at T+2; last plot (83,70) at T+65.
  - Colours equal q_p2 delayed one cycle; done at T+66.
- First cursor, col 0: no erase; 64 plots starting at (37,11). Then cursor col 4: 64 plots of colour 0 at x 37..44, then 64 plots at x 89..96, y 11..18; done at T+130.
- req_place and req_cursor high in the same IDLE cycle: ack_place first; ack_cursor on the first IDLE cycle after place done; no overlapping plots.
- Clamping: place_col = 7, place_row = 7 → base (115,24); last pixel (122,31).
- Reset asserted during DRAW at k = 30:
  - Next cycle vga_plot = 0, busy = 0, state IDLE.
  - Subsequent cursor request performs no erase (cursor_valid cleared).
